l1_memory_arbiter: RTL and testbench

Two-master arbiter that shares the single external memory request port between the L1 instruction cache refill path (master 0) and the L1 data cache (master 1). It accepts one word transfer at a time, drives the memory port from registers, and routes the returned data-valid strobe only to the granted master. Arbitration is round-robin per transfer, so interleaved single-word refill beats from both caches make forward progress.

---
 rtl/l1_memory_arbiter.sv | 160 ++++++++++++++++
 tb/tb_l1_memory_arbiter.sv | 302 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/l1_memory_arbiter.sv
// l1_memory_arbiter
//
// Shares one external memory request port between the L1 I-cache refill path
// (master 0) and the L1 D-cache (master 1). One word transfer is outstanding
// at a time; the memory port is driven from registers and the returned
// data-valid strobe is routed only to the granted master. Simultaneous
// requests are resolved by a per-transfer round-robin pointer.
//
// Optional feature: define L1_MEM_ARB_TIMEOUT_EN to abort a transfer after
// TIMEOUT_CYCLES busy cycles without mem_data_valid (error pulse to the
// granted master). Without it, BUSY waits indefinitely and errors are tied 0.
//
// Ports:
//   clk, rst                  clock, asynchronous active-high reset
//   mX_addr/write/wdata/trans master X request (trans 2'b10 = request)
//   mX_data_valid             beat done for master X (combinational)
//   mX_error                  master X transfer aborted (registered pulse)
//   rdata                     mem_rdata broadcast
//   mem_addr/write/wdata      registered request, addr[1:0] forced 0
//   mem_trans                 2'b10 while a transfer is outstanding
//   mem_data_valid, mem_rdata memory response
//   grant                     current or last granted master

module l1_memory_arbiter #(
    parameter int unsigned TIMEOUT_CYCLES = 256
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] m0_addr,
    input  logic        m0_write,
    input  logic [31:0] m0_wdata,
    input  logic [1:0]  m0_trans,
    output logic        m0_data_valid,
    output logic        m0_error,
    input  logic [31:0] m1_addr,
    input  logic        m1_write,
    input  logic [31:0] m1_wdata,
    input  logic [1:0]  m1_trans,
    output logic        m1_data_valid,
    output logic        m1_error,
    output logic [31:0] rdata,
    output logic [31:0] mem_addr,
    output logic        mem_write,
    output logic [31:0] mem_wdata,
    output logic [1:0]  mem_trans,
    input  logic        mem_data_valid,
    input  logic [31:0] mem_rdata,
    output logic        grant
);

    typedef enum logic [0:0] {StIdle, StBusy} state_e;

    state_e      state_q;
    logic        rr_q;
    logic        grant_q;
    logic        busy_q;
    logic [31:0] mem_addr_q;
    logic        mem_write_q;
    logic [31:0] mem_wdata_q;

    logic m0_req, m1_req, any_req, sel_d;

    always_comb begin
        m0_req  = (m0_trans == 2'b10);
        m1_req  = (m1_trans == 2'b10);
        any_req = m0_req | m1_req;
        // Round-robin pointer only matters when both masters contend.
        sel_d   = (m0_req && m1_req) ? rr_q : m1_req;
    end

    // Word addresses: the byte-offset bits are deliberately dropped.
    logic unused_addr_bits;
    assign unused_addr_bits = ^{m0_addr[1:0], m1_addr[1:0]};

`ifdef L1_MEM_ARB_TIMEOUT_EN
    localparam logic [15:0] TmoLast = 16'(TIMEOUT_CYCLES - 1);
    logic [15:0] tmo_cnt_q;
    logic        m0_error_q, m1_error_q;
`else
    logic unused_timeout_param;
    assign unused_timeout_param = ^TIMEOUT_CYCLES;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= StIdle;
            rr_q        <= 1'b0;
            grant_q     <= 1'b0;
            busy_q      <= 1'b0;
            mem_addr_q  <= 32'h0;
            mem_write_q <= 1'b0;
            mem_wdata_q <= 32'h0;
`ifdef L1_MEM_ARB_TIMEOUT_EN
            tmo_cnt_q   <= 16'h0;
            m0_error_q  <= 1'b0;
            m1_error_q  <= 1'b0;
`endif
        end else begin
`ifdef L1_MEM_ARB_TIMEOUT_EN
            m0_error_q <= 1'b0;
            m1_error_q <= 1'b0;
`endif
            unique case (state_q)
                StIdle: begin
                    if (any_req) begin
                        grant_q     <= sel_d;
                        busy_q      <= 1'b1;
                        mem_addr_q  <= sel_d ? {m1_addr[31:2], 2'b00}
                                             : {m0_addr[31:2], 2'b00};
                        mem_write_q <= sel_d ? m1_write : m0_write;
                        mem_wdata_q <= sel_d ? m1_wdata : m0_wdata;
                        state_q     <= StBusy;
`ifdef L1_MEM_ARB_TIMEOUT_EN
                        tmo_cnt_q   <= 16'h0;
`endif
                    end
                end
                StBusy: begin
                    // Completion has priority over a coincident timeout.
                    if (mem_data_valid) begin
                        busy_q  <= 1'b0;
                        rr_q    <= ~grant_q;
                        state_q <= StIdle;
`ifdef L1_MEM_ARB_TIMEOUT_EN
                    end else if (tmo_cnt_q == TmoLast) begin
                        busy_q     <= 1'b0;
                        rr_q       <= ~grant_q;
                        state_q    <= StIdle;
                        m0_error_q <= ~grant_q;
                        m1_error_q <= grant_q;
                    end else begin
                        tmo_cnt_q <= tmo_cnt_q + 16'd1;
`endif
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    // Strobes gated by state so an asynchronous reset kills them at once.
    assign m0_data_valid = mem_data_valid && (state_q == StBusy) && !grant_q;
    assign m1_data_valid = mem_data_valid && (state_q == StBusy) && grant_q;

`ifdef L1_MEM_ARB_TIMEOUT_EN
    assign m0_error = m0_error_q;
    assign m1_error = m1_error_q;
`else
    assign m0_error = 1'b0;
    assign m1_error = 1'b0;
`endif

    assign rdata     = mem_rdata;
    assign mem_addr  = mem_addr_q;
    assign mem_write = mem_write_q;
    assign mem_wdata = mem_wdata_q;
    assign mem_trans = {busy_q, 1'b0};
    assign grant     = grant_q;

endmodule

// File: tb/tb_l1_memory_arbiter.sv
module tb_l1_memory_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] m0_addr, m0_wdata, m1_addr, m1_wdata;
    logic        m0_write, m1_write;
    logic [1:0]  m0_trans, m1_trans;
    logic        m0_data_valid, m0_error, m1_data_valid, m1_error;
    logic [31:0] rdata, mem_addr, mem_wdata, mem_rdata;
    logic        mem_write, mem_data_valid, grant;
    logic [1:0]  mem_trans;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    l1_memory_arbiter #(.TIMEOUT_CYCLES(4)) dut (
        .clk           (clk),
        .rst           (rst),
        .m0_addr       (m0_addr),
        .m0_write      (m0_write),
        .m0_wdata      (m0_wdata),
        .m0_trans      (m0_trans),
        .m0_data_valid (m0_data_valid),
        .m0_error      (m0_error),
        .m1_addr       (m1_addr),
        .m1_write      (m1_write),
        .m1_wdata      (m1_wdata),
        .m1_trans      (m1_trans),
        .m1_data_valid (m1_data_valid),
        .m1_error      (m1_error),
        .rdata         (rdata),
        .mem_addr      (mem_addr),
        .mem_write     (mem_write),
        .mem_wdata     (mem_wdata),
        .mem_trans     (mem_trans),
        .mem_data_valid(mem_data_valid),
        .mem_rdata     (mem_rdata),
        .grant         (grant)
    );

    // Inputs change and outputs are sampled 1 time unit after the rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_reset();
        rst = 1'b1;
        #2;
        rst = 1'b0;
    endtask

    task automatic test_reset();
        #1;
        n_checks++;
        if ({mem_trans, mem_addr, mem_write, mem_wdata, grant} !== 68'h0) begin
            n_fail++;
            $display("FAIL reset_outputs: got trans=%b addr=%h w=%b wd=%h g=%b want all 0",
                     mem_trans, mem_addr, mem_write, mem_wdata, grant);
        end
        n_checks++;
        if ({m0_error, m1_error, m0_data_valid, m1_data_valid} !== 4'b0) begin
            n_fail++;
            $display("FAIL reset_strobes: got %b want 0000",
                     {m0_error, m1_error, m0_data_valid, m1_data_valid});
        end
        tick();
        rst = 1'b0;
    endtask

    task automatic test_single_read();
        m0_trans = 2'b10;
        m0_addr  = 32'h0000_1004;
        tick();
        m0_trans = 2'b00;
        n_checks++;
        if (mem_trans !== 2'b10 || mem_addr !== 32'h0000_1004 || grant !== 1'b0) begin
            n_fail++;
            $display("FAIL single_req: got trans=%b addr=%h grant=%b want 10 00001004 0",
                     mem_trans, mem_addr, grant);
        end
        tick();
        tick();
        mem_data_valid = 1'b1;
        mem_rdata      = 32'hE3A0_0001;
        #1;
        n_checks++;
        if (m0_data_valid !== 1'b1 || m1_data_valid !== 1'b0 || rdata !== 32'hE3A0_0001) begin
            n_fail++;
            $display("FAIL single_resp: got dv0=%b dv1=%b rdata=%h want 1 0 e3a00001",
                     m0_data_valid, m1_data_valid, rdata);
        end
        tick();
        mem_data_valid = 1'b0;
        #1;
        n_checks++;
        if (mem_trans !== 2'b00 || m0_data_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL single_done: got trans=%b dv0=%b want 00 0", mem_trans, m0_data_valid);
        end
    endtask

    task automatic test_both_request();
        logic exp_g [3] = '{1'b0, 1'b1, 1'b0};
        logic [31:0] exp_a [3] = '{32'h100, 32'h200, 32'h100};
        pulse_reset();
        m0_addr  = 32'h100;
        m1_addr  = 32'h200;
        m0_trans = 2'b10;
        m1_trans = 2'b10;
        for (int r = 0; r < 3; r++) begin
            tick();
            n_checks++;
            if (grant !== exp_g[r] || mem_addr !== exp_a[r] || mem_trans !== 2'b10) begin
                n_fail++;
                $display("FAIL both_round%0d: got grant=%b addr=%h trans=%b want %b %h 10",
                         r, grant, mem_addr, mem_trans, exp_g[r], exp_a[r]);
            end
            mem_data_valid = 1'b1;
            #1;
            n_checks++;
            if (m0_data_valid !== ~exp_g[r] || m1_data_valid !== exp_g[r]) begin
                n_fail++;
                $display("FAIL both_route%0d: got dv0=%b dv1=%b want %b %b",
                         r, m0_data_valid, m1_data_valid, ~exp_g[r], exp_g[r]);
            end
            tick();
            mem_data_valid = 1'b0;
        end
        m0_trans = 2'b00;
        m1_trans = 2'b00;
    endtask

    task automatic test_no_starve();
        logic exp_g [3] = '{1'b0, 1'b1, 1'b0};
        pulse_reset();
        m0_addr  = 32'h400;
        m1_addr  = 32'h800;
        m0_trans = 2'b10;
        for (int r = 0; r < 3; r++) begin
            tick();
            n_checks++;
            if (grant !== exp_g[r] || mem_trans !== 2'b10) begin
                n_fail++;
                $display("FAIL starve_order%0d: got grant=%b trans=%b want %b 10",
                         r, grant, mem_trans, exp_g[r]);
            end
            if (r == 0) m1_trans = 2'b10;
            if (r == 1) m1_trans = 2'b00;
            tick();
            mem_data_valid = 1'b1;
            tick();
            mem_data_valid = 1'b0;
        end
        m0_trans = 2'b00;
    endtask

    task automatic test_write();
        m1_write = 1'b1;
        m1_wdata = 32'hDEAD_BEEF;
        m1_addr  = 32'h2000_0003;
        m1_trans = 2'b10;
        tick();
        m1_write = 1'b0;
        m1_wdata = 32'h1234_5678;
        m1_addr  = 32'h0000_0F00;
        m1_trans = 2'b00;
        for (int c = 0; c < 3; c++) begin
            n_checks++;
            if (mem_addr !== 32'h2000_0000 || mem_write !== 1'b1 ||
                mem_wdata !== 32'hDEAD_BEEF || mem_trans !== 2'b10 || grant !== 1'b1) begin
                n_fail++;
                $display("FAIL write_hold%0d: got addr=%h w=%b wd=%h trans=%b g=%b want 20000000 1 deadbeef 10 1",
                         c, mem_addr, mem_write, mem_wdata, mem_trans, grant);
            end
            tick();
        end
        mem_data_valid = 1'b1;
        #1;
        n_checks++;
        if (m1_data_valid !== 1'b1 || m0_data_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL write_resp: got dv0=%b dv1=%b want 0 1", m0_data_valid, m1_data_valid);
        end
        tick();
        mem_data_valid = 1'b0;
    endtask

    task automatic test_reset_mid();
        m1_addr  = 32'h300;
        m1_write = 1'b1;
        m1_wdata = 32'h5;
        m1_trans = 2'b10;
        tick();
        m1_trans = 2'b00;
        n_checks++;
        if (grant !== 1'b1 || mem_trans !== 2'b10) begin
            n_fail++;
            $display("FAIL midrst_pre: got grant=%b trans=%b want 1 10", grant, mem_trans);
        end
        rst = 1'b1;
        mem_data_valid = 1'b1;
        #1;
        n_checks++;
        if ({mem_trans, mem_addr, mem_write, mem_wdata, grant} !== 68'h0 ||
            m0_data_valid !== 1'b0 || m1_data_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL midrst_async: got trans=%b addr=%h w=%b wd=%h g=%b dv=%b%b want all 0",
                     mem_trans, mem_addr, mem_write, mem_wdata, grant,
                     m0_data_valid, m1_data_valid);
        end
        tick();
        rst = 1'b0;
        #1;
        n_checks++;
        if (m0_data_valid !== 1'b0 || m1_data_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL midrst_idle_dv: got dv0=%b dv1=%b want 0 0", m0_data_valid, m1_data_valid);
        end
        tick();
        n_checks++;
        if (mem_trans !== 2'b00 || m1_data_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL midrst_after: got trans=%b dv1=%b want 00 0", mem_trans, m1_data_valid);
        end
        mem_data_valid = 1'b0;
    endtask

`ifdef L1_MEM_ARB_TIMEOUT_EN
    task automatic test_timeout();
        pulse_reset();
        m0_addr  = 32'hA00;
        m1_addr  = 32'hB00;
        m0_trans = 2'b10;
        m1_trans = 2'b10;
        tick();
        m0_trans = 2'b00;
        tick();
        tick();
        tick();
        n_checks++;
        if (mem_trans !== 2'b10 || grant !== 1'b0 || m0_error !== 1'b0) begin
            n_fail++;
            $display("FAIL tmo_before: got trans=%b g=%b err0=%b want 10 0 0",
                     mem_trans, grant, m0_error);
        end
        tick();
        n_checks++;
        if (mem_trans !== 2'b00 || m0_error !== 1'b1 || m1_error !== 1'b0) begin
            n_fail++;
            $display("FAIL tmo_abort: got trans=%b err0=%b err1=%b want 00 1 0",
                     mem_trans, m0_error, m1_error);
        end
        tick();
        m1_trans = 2'b00;
        n_checks++;
        if (m0_error !== 1'b0 || grant !== 1'b1 || mem_trans !== 2'b10 ||
            mem_addr !== 32'hB00) begin
            n_fail++;
            $display("FAIL tmo_next: got err0=%b g=%b trans=%b addr=%h want 0 1 10 00000b00",
                     m0_error, grant, mem_trans, mem_addr);
        end
        mem_data_valid = 1'b1;
        tick();
        mem_data_valid = 1'b0;
    endtask
`endif

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst            = 1'b1;
        m0_addr        = '0;
        m0_write       = 1'b0;
        m0_wdata       = '0;
        m0_trans       = 2'b00;
        m1_addr        = '0;
        m1_write       = 1'b0;
        m1_wdata       = '0;
        m1_trans       = 2'b00;
        mem_data_valid = 1'b0;
        mem_rdata      = '0;
        test_reset();
        test_single_read();
        test_both_request();
        test_no_starve();
        test_write();
        test_reset_mid();
`ifdef L1_MEM_ARB_TIMEOUT_EN
        test_timeout();
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
